// File: rtl/axil_sram_responder_pkg.sv
// Shared constants for the AXI4-Lite SRAM responder: response codes, FSM encodings
// and the strobe width.
package axil_sram_responder_pkg;

    localparam int STRB_W = 8;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RD_WAIT    = 3'd1;
    localparam logic [2:0] ST_RD_RESP    = 3'd2;
    localparam logic [2:0] ST_WR_COLLECT = 3'd3;
    localparam logic [2:0] ST_WR_RESP    = 3'd4;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

endpackage

// File: rtl/axil_sram_responder_if.sv
// AXI4-Lite bus bundle between the core's fetch/load-store master and the SRAM responder.
interface axil_sram_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    import axil_sram_responder_pkg::*;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    axi_resp_t         rresp;
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    axi_resp_t         bresp;

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/axil_sram_responder_sram.sv
// Single-port synchronous 64-bit SRAM with byte write mask. The read register only
// updates on reads, so it holds the last read word across later writes.
module sram_1rw_64 #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [7:0]       be_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);
    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 8; b++) begin
                    if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_sram_responder.sv
// AXI4-Lite responder in front of a 64-bit SRAM: one outstanding transaction,
// round-robin read/write arbitration, fixed read latency, DECERR outside the window.
module axil_sram_responder
    import axil_sram_responder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                RD_LAT    = 1
) (
    input logic                  clk,
    input logic                  rst,
    axil_sram_responder_if.slave axi
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             ok;
        logic [IDX_W-1:0] idx;
    } dec_t;

    function automatic dec_t decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] widx;
        dec_t              d;
        widx  = (a - BASE_ADDR) >> 3;
        d.ok  = (a >= BASE_ADDR) && (widx < ADDR_W'(DEPTH));
        d.idx = widx[IDX_W-1:0];
        return d;
    endfunction

    logic [2:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic              rvalid_q, rvalid_d, rd_ok_q, rd_ok_d, bvalid_q, bvalid_d;
    axi_resp_t         rresp_q, rresp_d, bresp_q, bresp_d;

    logic              arready, awready, wready, grant_rd, rd_fire;
    logic [ADDR_W-1:0] rd_fire_addr;
    dec_t              rd_dec, wr_dec;
    logic              sram_en, sram_we;
    logic [IDX_W-1:0]  sram_idx;
    logic [7:0]        sram_be;
    logic [63:0]       sram_rdata;

    assign rd_dec = decode(rd_fire_addr);
    assign wr_dec = decode(wr_addr_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_strb_d    = wr_strb_q;
        aw_got_d     = aw_got_q;
        w_got_d      = w_got_q;
        rvalid_d     = rvalid_q;
        rd_ok_d      = rd_ok_q;
        rresp_d      = rresp_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        arready      = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        rd_fire      = 1'b0;
        rd_fire_addr = rd_addr_q;
        sram_en      = 1'b0;
        sram_we      = 1'b0;
        sram_idx     = '0;
        sram_be      = '0;
        grant_rd     = axi.arvalid &
                       (~(axi.awvalid | axi.wvalid) | (last_grant_q == GRANT_WRITE));

        case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    arready   = 1'b1;
                    rd_addr_d = axi.araddr;
                    if (RD_LAT == 1) begin
                        rd_fire      = 1'b1;
                        rd_fire_addr = axi.araddr;
                    end else begin
                        cnt_d   = 4'(RD_LAT - 1);
                        state_d = ST_RD_WAIT;
                    end
                end else if (axi.awvalid | axi.wvalid) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    state_d  = ST_WR_COLLECT;
                end
            end
            ST_RD_WAIT: begin
                // Counter reaches zero at this edge: issue the SRAM read so its output
                // register and rvalid appear together.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) rd_fire = 1'b1;
            end
            ST_RD_RESP: begin
                if (axi.rready) begin
                    rvalid_d     = 1'b0;
                    last_grant_d = GRANT_READ;
                    state_d      = ST_IDLE;
                end
            end
            ST_WR_COLLECT: begin
                awready = ~aw_got_q;
                wready  = ~w_got_q;
                if (aw_got_q & w_got_q) begin
                    sram_en  = wr_dec.ok;
                    sram_we  = 1'b1;
                    sram_idx = wr_dec.idx;
                    sram_be  = wr_strb_q;
                    bvalid_d = 1'b1;
                    bresp_d  = wr_dec.ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
                    state_d  = ST_WR_RESP;
                end else begin
                    if (axi.awvalid & ~aw_got_q) begin
                        aw_got_d  = 1'b1;
                        wr_addr_d = axi.awaddr;
                    end
                    if (axi.wvalid & ~w_got_q) begin
                        w_got_d   = 1'b1;
                        wr_data_d = axi.wdata;
                        wr_strb_d = axi.wstrb;
                    end
                end
            end
            ST_WR_RESP: begin
                if (axi.bready) begin
                    bvalid_d     = 1'b0;
                    last_grant_d = GRANT_WRITE;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_fire) begin
            sram_en  = rd_dec.ok;
            sram_idx = rd_dec.idx;
            rvalid_d = 1'b1;
            rd_ok_d  = rd_dec.ok;
            rresp_d  = rd_dec.ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            state_d  = ST_RD_RESP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_WRITE;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            aw_got_q     <= 1'b0;
            w_got_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rd_ok_q      <= 1'b0;
            rresp_q      <= AXI_RESP_OKAY;
            bvalid_q     <= 1'b0;
            bresp_q      <= AXI_RESP_OKAY;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_strb_q    <= wr_strb_d;
            aw_got_q     <= aw_got_d;
            w_got_q      <= w_got_d;
            rvalid_q     <= rvalid_d;
            rd_ok_q      <= rd_ok_d;
            rresp_q      <= rresp_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
        end
    end

    sram_1rw_64 #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sram (
        .clk     (clk),
        .en_i    (sram_en),
        .we_i    (sram_we),
        .idx_i   (sram_idx),
        .be_i    (sram_be),
        .wdata_i (wr_data_q),
        .rdata_o (sram_rdata)
    );

    // arready is combinational from IDLE, so mask it while reset holds the FSM there.
    assign axi.arready = arready & ~rst;
    assign axi.awready = awready;
    assign axi.wready  = wready;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rd_ok_q ? sram_rdata : '0;
    assign axi.rresp   = rresp_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axil_sram_responder.sv
// Scoreboard bench for axil_sram_responder: stimulus pushes expected R/B responses,
// a negedge monitor pops and compares whenever a response handshakes.
module tb_axil_sram_responder;
    import axil_sram_responder_pkg::*;

    localparam int          RD_LAT = 3;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_sram_responder_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axil_sram_responder #(
        .ADDR_W(32), .DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .axi (bus)
    );

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [7:0]  gq[$];
    int          n_vec = 0, n_err = 0;
    int          cyc = 0, ar_cyc = 0;
    int          tmo_cnt = 0, tmo_seen = 0;
    bit          done = 1'b0;
    logic        prv_rv = 1'b0, prv_rr = 1'b0, prv_bv = 1'b0, prv_br = 1'b0;
    logic [63:0] prv_rd = '0;
    logic [1:0]  prv_rresp = '0, prv_bresp = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        rexp_t e;
        cyc++;
        if (tmo_cnt != tmo_seen) begin
            chk("handshake_timeout", 128'(tmo_cnt), 128'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        if (rst) begin
            chk("reset_outputs", {bus.arready, bus.rvalid, bus.rdata, bus.rresp,
                                  bus.awready, bus.wready, bus.bvalid, bus.bresp}, '0);
            prv_rv = 1'b0;
            prv_bv = 1'b0;
        end else begin
            if (bus.arvalid && bus.arready) begin
                ar_cyc = cyc;
                if (gq.size() > 0) chk("grant_order", "R", gq.pop_front());
            end
            if (bus.awvalid && bus.awready && gq.size() > 0)
                chk("grant_order", "W", gq.pop_front());
            if (bus.rvalid && !prv_rv) chk("rd_latency", 128'(cyc - ar_cyc), 128'(RD_LAT));
            if (prv_rv && !prv_rr)
                chk("r_hold", {bus.rvalid, bus.rdata, bus.rresp}, {1'b1, prv_rd, prv_rresp});
            if (prv_bv && !prv_br)
                chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, prv_bresp});
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("rdata", bus.rdata, e.data);
                    chk("rresp", bus.rresp, e.resp);
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", bus.bresp, bq.pop_front());
            end
            prv_rv = bus.rvalid;  prv_rr = bus.rready;  prv_rd = bus.rdata;
            prv_rresp = bus.rresp; prv_bv = bus.bvalid; prv_br = bus.bready;
            prv_bresp = bus.bresp;
        end
        if (done) begin
            chk("r_queue_empty", 128'(rq.size()), 0);
            chk("b_queue_empty", 128'(bq.size()), 0);
            chk("grant_queue_empty", 128'(gq.size()), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      input logic [1:0] r, input int awdly, input int wdly);
        bit awd = 1'b0, wd = 1'b0, gotb = 1'b0;
        bq.push_back(r);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        for (int i = 0; i < 60 && !(awd && wd); i++) begin
            bus.awvalid = !awd && (i >= awdly);
            bus.wvalid  = !wd && (i >= wdly);
            @(negedge clk);
            if (bus.awvalid && bus.awready) awd = 1'b1;
            if (bus.wvalid && bus.wready) wd = 1'b1;
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!(awd && wd)) tmo_cnt++;
        for (int i = 0; i < 60 && !gotb; i++) begin
            @(negedge clk);
            gotb = bus.bvalid && bus.bready;
            @(posedge clk); #1;
        end
        if (!gotb) tmo_cnt++;
    endtask

    task automatic rd(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r);
        bit hs = 1'b0, gotr = 1'b0;
        rexp_t e;
        e.data = d; e.resp = r;
        rq.push_back(e);
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk); #1;
        end
        bus.arvalid = 1'b0;
        if (!hs) tmo_cnt++;
        for (int i = 0; i < 60 && !gotr; i++) begin
            @(negedge clk);
            gotr = bus.rvalid && bus.rready;
            @(posedge clk); #1;
        end
        if (!gotr) tmo_cnt++;
    endtask

    initial begin
        int  nar, naw, nr, nb, rh, bh;
        bit  hs;
        rexp_t e;
        bus.arvalid = 0; bus.araddr = '0; bus.rready = 1; bus.awvalid = 0; bus.awaddr = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic write then read; unaligned address aliases the same word
        wr(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, AXI_RESP_OKAY, 0, 0);
        rd(32'h8000_0008, 64'h1122_3344_5566_7788, AXI_RESP_OKAY);
        // Low-half strobe
        wr(32'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, AXI_RESP_OKAY, 0, 0);
        rd(32'h8000_0008, 64'h1122_3344_BBBB_BBBB, AXI_RESP_OKAY);
        rd(32'h8000_000C, 64'h1122_3344_BBBB_BBBB, AXI_RESP_OKAY);
        // W leads AW by 3 cycles, then both together
        wr(32'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, AXI_RESP_OKAY, 3, 0);
        wr(32'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, AXI_RESP_OKAY, 0, 0);
        rd(32'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, AXI_RESP_OKAY);
        rd(32'h8000_0020, 64'h0123_4567_89AB_CDEF, AXI_RESP_OKAY);
        // Range boundaries; the DECERR write would alias word 0 if not blocked
        wr(32'h8000_0000, 64'hA5A5_0000_5A5A_FFFF, 8'hFF, AXI_RESP_OKAY, 0, 0);
        wr(32'h8000_7FF8, 64'h7777_6666_5555_4444, 8'hFF, AXI_RESP_OKAY, 0, 0);
        rd(32'h8000_7FF8, 64'h7777_6666_5555_4444, AXI_RESP_OKAY);
        rd(32'h7FFF_FFF8, 64'h0, AXI_RESP_DECERR);
        wr(32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, AXI_RESP_DECERR, 0, 0);
        rd(32'h8000_0000, 64'hA5A5_0000_5A5A_FFFF, AXI_RESP_OKAY);
        wr(32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, AXI_RESP_OKAY, 0, 0);
        rd(32'h8000_0008, 64'h1122_3344_BBBB_BBBB, AXI_RESP_OKAY);

        // Contending read/write held high; responses back-pressured for 5 cycles
        wr(32'h8000_0010, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, AXI_RESP_OKAY, 0, 0);
        e.data = 64'h0F0E_0D0C_0B0A_0908; e.resp = AXI_RESP_OKAY;
        rq.push_back(e); rq.push_back(e);
        bq.push_back(AXI_RESP_OKAY); bq.push_back(AXI_RESP_OKAY);
        gq.push_back("R"); gq.push_back("W"); gq.push_back("R"); gq.push_back("W");
        bus.araddr = 32'h8000_0010; bus.awaddr = 32'h8000_0010;
        bus.wdata = 64'h0F0E_0D0C_0B0A_0908; bus.wstrb = 8'hFF;
        bus.arvalid = 1; bus.awvalid = 1; bus.wvalid = 1; bus.rready = 0; bus.bready = 0;
        nar = 0; naw = 0; nr = 0; nb = 0; rh = 0; bh = 0;
        for (int c = 0; c < 200 && (nr < 2 || nb < 2); c++) begin
            @(negedge clk);
            if (bus.arvalid && bus.arready) nar++;
            if (bus.awvalid && bus.awready) naw++;
            if (bus.rvalid && bus.rready) nr++;
            if (bus.bvalid && bus.bready) nb++;
            if (bus.rvalid && !bus.rready) rh++;
            if (bus.bvalid && !bus.bready) bh++;
            @(posedge clk); #1;
            if (nar >= 2) bus.arvalid = 0;
            if (naw >= 2) begin bus.awvalid = 0; bus.wvalid = 0; end
            bus.rready = (rh >= 5);
            bus.bready = (bh >= 5);
        end
        if (nr < 2 || nb < 2) tmo_cnt++;
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.rready = 1; bus.bready = 1;

        // Reset during RD_WAIT, then during WR_COLLECT; neither responds
        wr(32'h8000_0030, 64'h5555_5555_5555_5555, 8'hFF, AXI_RESP_OKAY, 0, 0);
        bus.araddr = 32'h8000_0030; bus.arvalid = 1; hs = 0;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk); #1;
        end
        if (!hs) tmo_cnt++;
        bus.arvalid = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.awaddr = 32'h8000_0030; bus.wdata = 64'h6666_6666_6666_6666; bus.wstrb = 8'hFF;
        bus.wvalid = 1; hs = 0;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            hs = bus.wvalid && bus.wready;
            @(posedge clk); #1;
        end
        if (!hs) tmo_cnt++;
        bus.wvalid = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd(32'h8000_0030, 64'h5555_5555_5555_5555, AXI_RESP_OKAY);

        repeat (3) @(posedge clk);
        #1 done = 1'b1;
        repeat (5) @(posedge clk);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors %0d errors", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
